// File: rtl/uart_transmitter_pkg.sv
// Shared UART configuration encodings and transmitter state type.
// Also holds small helpers that turn a configuration into frame-shape facts.
package uart_transmitter_pkg;

  localparam int OVERSAMPLE_RATE = 16;

  localparam logic [1:0] DW_5BIT = 2'b00;
  localparam logic [1:0] DW_6BIT = 2'b01;
  localparam logic [1:0] DW_7BIT = 2'b10;
  localparam logic [1:0] DW_8BIT = 2'b11;

  localparam logic [1:0] EVEN      = 2'b00;
  localparam logic [1:0] ODD       = 2'b01;
  localparam logic [1:0] DISABLED1 = 2'b10;
  localparam logic [1:0] DISABLED2 = 2'b11;

  localparam logic [1:0] SB_1BIT   = 2'b00;
  localparam logic [1:0] SB_2BIT   = 2'b01;
  localparam logic [1:0] RESERVED1 = 2'b10;
  localparam logic [1:0] RESERVED2 = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic [1:0] data_width;
    logic [1:0] parity_mode;
    logic [1:0] stop_bits;
  } uart_config_s;

  // Index of the last data bit: 4..7 for the four width codes.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] dw);
    return 3'd4 + {1'b0, dw};
  endfunction

  function automatic logic parity_enabled(input logic [1:0] pm);
    return (pm == EVEN) || (pm == ODD);
  endfunction

  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic [1:0] dw,
                                       input logic [1:0] pm);
    logic [7:0] mask;
    logic       x;
    mask = 8'hFF >> (2'd3 - dw);
    x    = ^(data & mask);
    return (pm == ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART frame serializer: start bit, 5-8 data bits LSB first, optional parity,
// 1-2 stop bits, each bit lasting OVERSAMPLE baud ticks.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_RATE
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       ov_baud_rt_i,
  input  logic [7:0] data_tx_i,
  input  logic       tx_req_i,
  input  logic [1:0] data_width_i,
  input  logic [1:0] parity_mode_i,
  input  logic [1:0] stop_bits_i,
  output logic       tx_o,
  output logic       tx_ready_o,
  output logic       tx_done_o
);

  localparam int TCW = $clog2(OVERSAMPLE);

  tx_state_e     r_state;
  logic [TCW-1:0] r_tick_cnt;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  uart_config_s  r_cfg;
  logic          r_parity;
  logic          r_tx;
  logic          r_done;

  logic w_accept;
  logic w_bit_end;
  logic w_last_data;
  logic w_parity_on;
  logic w_two_stop;

  assign w_accept    = tx_req_i && (r_state == IDLE);
  assign w_bit_end   = ov_baud_rt_i && (r_tick_cnt == TCW'(OVERSAMPLE - 1));
  assign w_last_data = (r_bit_cnt == last_bit_idx(r_cfg.data_width));
  assign w_parity_on = parity_enabled(r_cfg.parity_mode);
  assign w_two_stop  = (r_cfg.stop_bits == SB_2BIT);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_cfg      <= '0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      // NOTE: default-low here makes tx_done_o a single-cycle pulse without extra logic.
      r_done <= 1'b0;
      if (r_state != IDLE && ov_baud_rt_i)
        r_tick_cnt <= r_tick_cnt + TCW'(1);

      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state    <= START;
            r_tx       <= 1'b0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= data_tx_i;
            r_cfg      <= '{data_width: data_width_i,
                            parity_mode: parity_mode_i,
                            stop_bits: stop_bits_i};
            r_parity   <= calc_parity(data_tx_i, data_width_i, parity_mode_i);
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (w_last_data) begin
              r_bit_cnt <= '0;
              if (w_parity_on) begin
                r_state <= PARITY;
                r_tx    <= r_parity;
              end else begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
          end
        end
        STOP: begin
          // Bit counter is reused to count stop bits.
          if (w_bit_end) begin
            if (w_two_stop && r_bit_cnt == 3'd0) begin
              r_bit_cnt <= 3'd1;
            end else begin
              r_state   <= IDLE;
              r_bit_cnt <= '0;
              r_done    <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_o       = r_tx;
  assign tx_ready_o = (r_state == IDLE);
  assign tx_done_o  = r_done;

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serializer stage feeding the TX line. Pops one data word per handshake from the TX FIFO / main controller and emits an asynchronous frame: start bit, 5-8 data bits LSB first, optional parity bit, 1-2 stop bits.
- Bit timing is derived from an external 16x oversampling baud tick.
- Frame format uses the shared UART configuration encodings (data width, parity mode, stop bits) and is latched per frame.

Parameters:
- OVERSAMPLE, 16, baud ticks per bit period (power of two; counter width is log2(OVERSAMPLE)).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  synchronous active-low reset
- ov_baud_rt_i  in  1  one-cycle pulse at 16x baud rate
- data_tx_i  in  8  word to transmit
- tx_req_i  in  1  request; sampled with tx_ready_o
- data_width_i  in  2  DW_5BIT..DW_8BIT
- parity_mode_i  in  2  EVEN / ODD / DISABLED1 / DISABLED2
- stop_bits_i  in  2  SB_1BIT / SB_2BIT / RESERVED1 / RESERVED2
- tx_o  out  1  serial line, idle high
- tx_ready_o  out  1  block is IDLE and can accept a word
- tx_done_o  out  1  one-cycle pulse: frame finished

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_n_i.
- Reset values: tx_o=1, tx_ready_o=1, tx_done_o=0, state=IDLE, tick counter=0, bit counter=0.
- Reset asserted mid-frame aborts the frame. tx_o=1 from the next edge; no tx_done_o pulse.
- Handshake:
  - A word is accepted on a rising edge where tx_req_i=1 and tx_ready_o=1.
  - On acceptance, data_tx_i, data_width_i, parity_mode_i and stop_bits_i are latched. Input changes during the frame have no effect.
  - tx_req_i while not ready is ignored, not queued.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE. PARITY is skipped when parity is disabled.
- Bit timing:
  - tx_o is registered and reflects the new state on the edge after acceptance. START drives 0.
  - Each bit lasts exactly 16 ov_baud_rt_i pulses. The tick counter increments on each pulse.
  - On the pulse that takes the counter from 15 to 0, the block advances to the next bit or state.
  - Cycles without a tick hold all state.
- DATA:
  - Sends bit[i], i=0..N-1, with N=5,6,7,8 for codes 00,01,10,11.
  - Bits above N-1 are ignored, including for parity.
  - The bit counter is 3 bits. DATA ends when counter==N-1 on the last tick.
- PARITY:
  - EVEN: XOR of the N data bits.
  - ODD: inverse of that XOR.
  - DISABLED1/DISABLED2: no parity bit.
- STOP:
  - Drives 1 for 1 bit (SB_1BIT) or 2 bits (SB_2BIT).
  - RESERVED1/RESERVED2 are treated as 1 stop bit.
- Frame end:
  - On the final tick of the last stop bit, state becomes IDLE.
  - tx_done_o=1 and tx_ready_o=1 in that first IDLE cycle.
  - A request in that same cycle is accepted, giving back-to-back frames with zero idle bit time.
- Frame length in ticks = 16*(1+N+P+S), where P is 0 or 1 and S is 1 or 2.
- A tick coincident with acceptance does not count toward the start bit. The tick counter is cleared on acceptance.

Decomposition:
- Shared package additions:
  - tx_state_e enum: IDLE, START, DATA, PARITY, STOP.
  - OVERSAMPLE_RATE = 16.
- Reuse the existing DW_*, EVEN/ODD/DISABLED*, SB_* and RESERVED* encodings and uart_config_s for the latched configuration.
- No sub-module. Parity is a single XOR reduction with a width mask. The baud tick comes from the existing baud generator upstream.

Test Plan:
- 8-bit, EVEN, 1 stop, data 0xA5:
  - Bits are 0,1,0,1,0,0,1,0,1,0(parity),1.
  - Each bit is held for 16 ticks; 176 ticks total.
  - tx_done_o pulses exactly once, then tx_ready_o=1.
- 5-bit, ODD, 2 stop, data 0xFF:
  - Line is 0,1,1,1,1,1,0(parity),1,1; 144 ticks.
  - Upper bits are ignored.
- 7-bit, DISABLED2, RESERVED1 stop, data 0x80:
  - Line is 0,0000000,1; 144 ticks.
  - Bit7 is not sent; single stop bit.
- Back-to-back: hold tx_req_i=1 with 0x55 then 0x0F (8-bit, DISABLED1, 1 stop).
  - The second start bit begins the edge after tx_done_o.
  - There is no extra high bit between the frames; 320 ticks total.
- Change data_width_i, parity_mode_i and data_tx_i mid-frame:
  - The frame is unchanged.
  - tx_req_i while busy is ignored, with no second frame.
- Assert rst_n_i=0 during DATA bit 3:
  - tx_o=1, tx_ready_o=1 and tx_done_o=0 after the next edge.
  - A subsequent request transmits a clean full frame.
